display_scan_ctrl: RTL
======================

Name: display_scan_ctrl

Overview:
Sequencing controller for the 8-digit multiplexed seven-segment display path (3-bit digit counter, 3-to-8 decoder, 8:1 nibble mux, BCD-to-7seg).
- Replaces the free-running digit counter with a prescaled scan.
- Double-buffers the 32-bit BCD word with a valid/ready load handshake, applying new values only at frame boundaries (no tearing).
- Adds per-digit enable, leading-zero blanking and 16-level brightness PWM.
- Its outputs drive the existing BCD_to_sevenSeg and the anode pins.

Parameters:
TICKS_PER_DIGIT, 100000, clock cycles per digit slot; must be a multiple of 16 and at least 16.
CNT_W, $clog2(TICKS_PER_DIGIT), prescaler width (derived, not overridden).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
bcd_in  input  32  new display word, nibble k = digit k (digit 0 = [3:0])
load_valid  input  1  bcd_in valid
load_ready  output  1  controller can accept a word
digit_en  input  8  per-digit enable mask, bit k = digit k
lz_blank  input  1  1 = blank leading zero digits
brightness  input  4  duty level 0..15
digit_sel  output  3  current digit index (feeds nibble mux)
bcd_out  output  4  nibble of current digit from the display register
anodos  output  8  active-low anodes, at most one bit low
frame_done  output  1  one-cycle pulse at the end of digit 7's slot

Behaviour:
Clock and reset:
- Single clock domain.
- All state updates on the rising edge of clock; reset is sampled only there (synchronous, active-low).

Reset values:
- prescaler 0, digit_sel 0, bcd_out 0, anodos 8'hFF, frame_done 0, load_ready 1.
- display_reg 0, shadow_reg 0, pending 0, state BLANK.
- Reset asserted mid-frame or mid-handshake discards shadow and pending; no partial load survives.

Prescaler:
- Counts 0..TICKS_PER_DIGIT-1, then wraps to 0.
- Slot end is cnt == TICKS_PER_DIGIT-1. On slot end, digit_sel increments modulo 8 (7 wraps to 0).
- Frame boundary is slot end with digit_sel == 7; frame_done is high on the cycle after it (registered), for exactly one cycle.

Load handshake:
- Accept when load_valid && load_ready: shadow_reg <= bcd_in, pending <= 1.
- load_ready = !pending.
- At a frame boundary with pending = 1: display_reg <= shadow_reg, pending <= 0, and load_ready returns high the next cycle.
- A word accepted on the boundary cycle itself (pending was 0) is applied at the next boundary, not the current one.
- load_valid while load_ready = 0 is ignored; the source must hold.

State machine:
- BLANK: all anodes off; scanning continues. On a frame boundary with pending = 1, go to SCAN.
- SCAN: normal display; stays in SCAN until reset.

Digit visibility, evaluated for the current digit k:
- blank_k = !digit_en[k], or (lz_blank && k != 0 && nibbles k..7 of display_reg all 0).
- Digit 0 is never leading-zero blanked.
- Nibbles greater than 9 are passed through unchanged; decoding them is the downstream block's job.

PWM:
- STEP = TICKS_PER_DIGIT/16. A digit is lit while cnt < brightness*STEP.
- brightness 0 gives dark; brightness 15 gives 15/16 duty.
- brightness is sampled every cycle; a change takes effect immediately, with no glitch beyond the next compare.

Outputs:
- Registered, with 1-cycle latency from prescaler and digit state.
- anodos = 8'hFF in BLANK, when blank_k, or when the PWM compare fails.
- Otherwise anodos = ~(8'b1 << k).
- bcd_out = display_reg[4k+3:4k] whenever in SCAN, regardless of blanking.
- digit_sel and anodos always refer to the same digit on the same cycle.

Decomposition:
Package display_pkg:
- enum scan_state_t {BLANK, SCAN}.
- Constants NUM_DIGITS = 8, DIGIT_W = 3, BRIGHT_LEVELS = 16.
Sub-module leading_zero_mask:
- Combinational; 32-bit display word plus lz_blank in, 8-bit blank mask out.
- Instantiated once and unit-testable alone.

Test Plan:
All scenarios use TICKS_PER_DIGIT = 16 (STEP = 1).
1. Reset, no load: run 3 frames -> anodos stays 8'hFF, load_ready = 1, frame_done pulses every 128 cycles, digit_sel cycles 0..7.
2. Load 32'h87654321, brightness 15, digit_en FF, lz_blank 0 -> accepted in 1 cycle, load_ready low until the boundary; the next frame shows bcd_out 1..8 with anodos FE, FD, ... 7F, each low for 15 of 16 cycles.
3. Load 32'h00000405, lz_blank 1 -> digits 7..3 dark, digit 2 shows 4, digit 1 shows 0 (not leading), digit 0 shows 5. Load 32'h0 -> only digit 0 lit, showing 0.
4. Second load during pending: assert load_valid with 32'hAAAA5555 while load_ready = 0 -> ignored. Assert it again on the boundary-cycle acceptance -> applied only at the following frame boundary; the earlier word is displayed for one full frame first.
5. Brightness sweep 0, 1, 8: per slot, anode low for 0, 1 and 8 cycles respectively. digit_en = 8'h0F -> digits 7..4 never lit.
6. Reset (reset = 0) mid-frame with pending = 1 -> next cycle anodos FF, state BLANK, pending cleared, load_ready 1, digit_sel 0, display_reg 0.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan path.
//   scan_state_t  : BLANK (anodes held off) / SCAN (normal display)
//   NUM_DIGITS    : digits on the display
//   DIGIT_W       : width of a digit index
//   BRIGHT_LEVELS : number of PWM brightness levels
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS    = 8;
  localparam int DIGIT_W       = 3;
  localparam int BRIGHT_LEVELS = 16;

endpackage

// File: rtl/display_scan_ctrl_leading_zero_mask.sv
// Leading-zero blank mask for the display word (combinational).
//   word_i     : BCD word, nibble k = digit k
//   lz_blank_i : 1 = blank leading zero digits
//   mask_o     : bit k set when digit k is a leading zero to be blanked
// Digit 0 is never blanked so a zero word still shows a single "0".
module leading_zero_mask
  import display_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] word_i,
  input  logic                    lz_blank_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  logic zeros_above;

  // Walk from the most significant digit down; a digit is leading only
  // while it and every digit above it are zero.
  always_comb begin
    mask_o      = '0;
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      zeros_above = zeros_above && (word_i[4*k +: 4] == 4'd0);
      mask_o[k]   = lz_blank_i && zeros_above;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for the multiplexed 8-digit seven-segment display.
//   clock_i, reset_i : system clock, synchronous active-low reset
//   bcd_in_i         : new display word (digit 0 = [3:0])
//   load_valid_i     : bcd_in_i valid; load_ready_o : word can be accepted
//   digit_en_i       : per-digit enable mask
//   lz_blank_i       : blank leading zero digits
//   brightness_i     : PWM duty level 0..15 (level/16)
//   digit_sel_o      : current digit index for the nibble mux
//   bcd_out_o        : nibble of the current digit
//   anodos_o         : active-low anodes, at most one low
//   frame_done_o     : one-cycle pulse after digit 7's slot ends
//
// state | meaning
// BLANK | no word shown yet, anodes held off, scan still running
// SCAN  | display_reg valid, digits lit per enable/blank/PWM
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter  int TICKS_PER_DIGIT = 100000,
  localparam int CNT_W           = $clog2(TICKS_PER_DIGIT)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [31:0]           bcd_in_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [NUM_DIGITS-1:0] digit_en_i,
  input  logic                  lz_blank_i,
  input  logic [3:0]            brightness_i,
  output logic [DIGIT_W-1:0]    digit_sel_o,
  output logic [3:0]            bcd_out_o,
  output logic [NUM_DIGITS-1:0] anodos_o,
  output logic                  frame_done_o
);

  localparam int                 STEP       = TICKS_PER_DIGIT / BRIGHT_LEVELS;
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic                  pending_q, pending_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           display_q, display_d;
  logic [DIGIT_W-1:0]    digit_sel_q, digit_sel_d;
  logic [3:0]            bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0] anodos_q, anodos_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end, frame_end, accept, blank, lit;
  logic [CNT_W:0]        pwm_thr;
  logic [NUM_DIGITS-1:0] lz_mask;

  leading_zero_mask u_lz_mask (
    .word_i     (display_q),
    .lz_blank_i (lz_blank_i),
    .mask_o     (lz_mask)
  );

  assign slot_end  = (cnt_q == CNT_MAX);
  assign frame_end = slot_end && (digit_q == LAST_DIGIT);
  assign accept    = load_valid_i && !pending_q;
  assign pwm_thr   = (CNT_W+1)'(brightness_i) * (CNT_W+1)'(STEP);
  assign blank     = !digit_en_i[digit_q] || lz_mask[digit_q];
  assign lit       = (state_q == SCAN) && !blank && ({1'b0, cnt_q} < pwm_thr);

  always_comb begin
    state_d      = state_q;
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    digit_d      = slot_end ? digit_q + 1'b1 : digit_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    display_d    = display_q;

    case (state_q)
      BLANK:   if (frame_end && pending_q) state_d = SCAN;
      SCAN:    state_d = SCAN;
      default: state_d = BLANK;
    endcase

    // pending blocks acceptance, so a boundary swap and a new accept
    // can never collide on the same cycle.
    if (frame_end && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = bcd_in_i;
      pending_d = 1'b1;
    end

    digit_sel_d  = digit_q;
    bcd_out_d    = display_q[{digit_q, 2'b00} +: 4];
    anodos_d     = lit ? ~(NUM_DIGITS'(1) << digit_q) : '1;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      digit_q      <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      display_q    <= '0;
      digit_sel_q  <= '0;
      bcd_out_q    <= '0;
      anodos_q     <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      digit_sel_q  <= digit_sel_d;
      bcd_out_q    <= bcd_out_d;
      anodos_q     <= anodos_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready_o = !pending_q;
  assign digit_sel_o  = digit_sel_q;
  assign bcd_out_o    = bcd_out_q;
  assign anodos_o     = anodos_q;
  assign frame_done_o = frame_done_q;

endmodule
